lfsr_scheduler: RTL and testbench

LFSR_SCHEDULER -- requirements
Module: lfsr_scheduler

---
 rtl/lfsr_pkg.sv | 46 ++++
 rtl/lfsr_core.sv | 51 +++++
 rtl/lfsr_scheduler.sv | 150 +++++++++++++++
 tb/tb_lfsr_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared constants, FSM state encoding and LFSR step function
//               for the LFSR-based random byte scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    // LFSR width; bit 1 of the polynomial numbering is the MSB (index 7).
    localparam int c_LFSR_WIDTH = 8;

    // Tap positions in polynomial numbering (x^8 + x^6 + x^5 + x^4 + 1).
    localparam int c_TAP_POS_0 = 8;
    localparam int c_TAP_POS_1 = 6;
    localparam int c_TAP_POS_2 = 5;
    localparam int c_TAP_POS_3 = 4;

    // Tap positions mapped onto vector indices: position N sits at index (WIDTH - N).
    localparam logic [c_LFSR_WIDTH-1:0] c_LFSR_TAP_MASK = c_LFSR_WIDTH'(
        (1 << (c_LFSR_WIDTH - c_TAP_POS_0)) |
        (1 << (c_LFSR_WIDTH - c_TAP_POS_1)) |
        (1 << (c_LFSR_WIDTH - c_TAP_POS_2)) |
        (1 << (c_LFSR_WIDTH - c_TAP_POS_3)));

    // Reset value and zero-seed substitute.
    localparam logic [c_LFSR_WIDTH-1:0] c_DEFAULT_SEED = 8'h07;

    // LFSR steps needed to produce one fresh byte.
    localparam int c_STEPS_PER_BYTE = 8;
    localparam int c_CNT_WIDTH      = 3;

    // Scheduler FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_SHIFT = 2'd1;
    localparam state_t c_ST_GRANT = 2'd2;

    // One LFSR step: feedback bit enters at position 1 (MSB), the rest shift
    // toward position 8 (LSB).
    function automatic logic [c_LFSR_WIDTH-1:0] lfsr_step(input logic [c_LFSR_WIDTH-1:0] s);
        lfsr_step = {^(s & c_LFSR_TAP_MASK), s[c_LFSR_WIDTH-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_core
// Description : 8-bit Fibonacci LFSR with seed load and step enables. A zero
//               seed is replaced by the reset seed so the register never
//               reaches the all-zero lock-up state.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter logic [c_LFSR_WIDTH-1:0] RESET_SEED = c_DEFAULT_SEED
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_step,
    input  logic [c_LFSR_WIDTH-1:0] i_seed,
    output logic [c_LFSR_WIDTH-1:0] o_state
);

    // A zero RESET_SEED would lock the LFSR, so fall back to 1 in that case.
    localparam logic [c_LFSR_WIDTH-1:0] c_SAFE_SEED =
        (RESET_SEED != '0) ? RESET_SEED : c_LFSR_WIDTH'(1);

    logic [c_LFSR_WIDTH-1:0] r_lfsr_q;
    logic [c_LFSR_WIDTH-1:0] w_lfsr_d;

    // Next LFSR value: load takes priority over step; zero seed is substituted.
    always_comb begin
        w_lfsr_d = r_lfsr_q;
        if (i_load) begin
            w_lfsr_d = (i_seed == '0) ? c_SAFE_SEED : i_seed;
        end else if (i_step) begin
            w_lfsr_d = lfsr_step(r_lfsr_q);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr_q <= c_SAFE_SEED;
        end else begin
            r_lfsr_q <= w_lfsr_d;
        end
    end

    assign o_state = r_lfsr_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_scheduler
// Description : Round-robin scheduler that hands out one fresh random byte
//               per grant. Each granted request waits for 8 LFSR steps, then
//               receives a one-cycle grant with the new byte on data.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_scheduler
    import lfsr_pkg::*;
#(
    parameter int                      NUM_REQ    = 2,
    parameter logic [c_LFSR_WIDTH-1:0] RESET_SEED = c_DEFAULT_SEED
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    seed_load,
    input  logic [c_LFSR_WIDTH-1:0] seed,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [c_LFSR_WIDTH-1:0] data,
    output logic                    busy
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_PTR_W-1:0]     c_LAST_IDX = c_PTR_W'(NUM_REQ - 1);
    localparam logic [c_CNT_WIDTH-1:0] c_LAST_STEP = c_CNT_WIDTH'(c_STEPS_PER_BYTE - 1);

    state_t                  r_state_q;
    state_t                  w_state_d;
    logic [c_CNT_WIDTH-1:0]  r_cnt_q;
    logic [c_CNT_WIDTH-1:0]  w_cnt_d;
    logic [c_PTR_W-1:0]      r_winner_q;
    logic [c_PTR_W-1:0]      w_winner_d;
    logic [c_PTR_W-1:0]      r_pointer_q;
    logic [c_PTR_W-1:0]      w_pointer_d;
    logic [c_LFSR_WIDTH-1:0] r_data_q;
    logic [c_LFSR_WIDTH-1:0] w_data_d;

    logic                    w_lfsr_load;
    logic                    w_lfsr_step;
    logic [c_LFSR_WIDTH-1:0] w_lfsr_state;
    logic [c_LFSR_WIDTH-1:0] w_lfsr_next;

    logic                    w_hi_found;
    logic [c_PTR_W-1:0]      w_hi_idx;
    logic [c_PTR_W-1:0]      w_lo_idx;
    logic [c_PTR_W-1:0]      w_rr_winner;

    lfsr_core #(
        .RESET_SEED (RESET_SEED)
    ) u_lfsr_core (
        .clk     (clock),
        .rst     (reset),
        .i_load  (w_lfsr_load),
        .i_step  (w_lfsr_step),
        .i_seed  (seed),
        .o_state (w_lfsr_state)
    );

    // Value the LFSR will hold after the current step; captured as the byte.
    assign w_lfsr_next = lfsr_step(w_lfsr_state);

    // Round-robin pick: lowest active index above the pointer, else lowest
    // active index at or below it (wrap-around).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(r_pointer_q)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_PTR_W'(i);
                end else begin
                    w_lo_idx   = c_PTR_W'(i);
                end
            end
        end
        w_rr_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // FSM next-state and datapath control.
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_winner_d  = r_winner_q;
        w_pointer_d = r_pointer_q;
        w_data_d    = r_data_q;
        w_lfsr_load = 1'b0;
        w_lfsr_step = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                // Seed loading wins over a simultaneous request.
                if (seed_load) begin
                    w_lfsr_load = 1'b1;
                end else if (|req) begin
                    w_winner_d = w_rr_winner;
                    w_cnt_d    = '0;
                    w_state_d  = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                w_lfsr_step = 1'b1;
                w_cnt_d     = r_cnt_q + 1'b1;
                if (r_cnt_q == c_LAST_STEP) begin
                    w_data_d  = w_lfsr_next;
                    w_state_d = c_ST_GRANT;
                end
            end
            c_ST_GRANT: begin
                w_pointer_d = r_winner_q;
                w_state_d   = c_ST_IDLE;
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q   <= c_ST_IDLE;
            r_cnt_q     <= '0;
            r_winner_q  <= '0;
            r_pointer_q <= c_LAST_IDX;
            r_data_q    <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_winner_q  <= w_winner_d;
            r_pointer_q <= w_pointer_d;
            r_data_q    <= w_data_d;
        end
    end

    // One-hot grant, only while in GRANT.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = (r_state_q == c_ST_GRANT) && (r_winner_q == c_PTR_W'(i));
        end
    end

    assign data = r_data_q;
    assign busy = (r_state_q != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_scheduler
// Description : Scoreboard bench for lfsr_scheduler. Stimulus pushes expected
//               grants (value, byte, cycle); a negedge monitor pops and
//               compares whenever gnt is non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_scheduler;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       seed_load = 1'b0;
    logic [7:0] seed      = 8'h00;
    logic [1:0] req       = 2'b00;
    logic [1:0] gnt;
    logic [7:0] data;
    logic       busy;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] gnt;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    lfsr_scheduler #(
        .NUM_REQ    (2),
        .RESET_SEED (8'h07)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .gnt       (gnt),
        .data      (data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Eight steps of x^8+x^6+x^5+x^4+1, in polynomial bit numbering (s[1]=MSB).
    function automatic logic [7:0] model_next_byte(input logic [7:0] v);
        logic s [1:8];
        logic nb;
        logic [7:0] r;
        for (int n = 1; n <= 8; n++) s[n] = v[8-n];
        repeat (8) begin
            nb = s[8] ^ s[6] ^ s[5] ^ s[4];
            for (int n = 8; n >= 2; n--) s[n] = s[n-1];
            s[1] = nb;
        end
        for (int n = 1; n <= 8; n++) r[8-n] = s[n];
        return r;
    endfunction

    task automatic expect_grant(input logic [1:0] g, input logic [7:0] d, input int at);
        exp_t e;
        e.gnt  = g;
        e.data = d;
        e.cyc  = at;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Monitor: flags missed, unexpected, non-one-hot or mistimed grants.
    always @(negedge clock) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_grant: got none by cycle %0d expected gnt=%b at cycle %0d",
                     cyc, sb_q[0].gnt, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        if (gnt !== 2'b00) begin
            check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: got gnt=%b at cycle %0d expected none", gnt, cyc);
            end else begin
                e = sb_q.pop_front();
                check("gnt_value",   32'(gnt),  32'(e.gnt));
                check("grant_data",  32'(data), 32'(e.data));
                check("grant_cycle", cyc,       e.cyc);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish by cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [7:0] b1, b2, b3, b4;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        @(negedge clock);
        check("reset_gnt",  32'(gnt),  32'h0);
        check("reset_data", 32'(data), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        tick();
        reset = 1'b0;

        // Single requester from reset: 8'h26 nine cycles after sampling
        base = cyc;
        req  = 2'b01;
        expect_grant(2'b01, 8'h26, base + 9);
        wait_until(base + 2);
        @(negedge clock);
        check("shift_busy", 32'(busy), 32'h1);
        check("shift_gnt",  32'(gnt),  32'h0);
        wait_until(base + 9);
        req = 2'b00;
        wait_until(base + 12);
        @(negedge clock);
        check("idle_busy", 32'(busy), 32'h0);
        check("data_hold", 32'(data), 32'h26);
        tick();

        // Seed FF then requester 1
        base      = cyc;
        seed      = 8'hFF;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        req       = 2'b10;
        expect_grant(2'b10, 8'hD0, base + 10);
        wait_until(base + 10);
        req = 2'b00;
        wait_until(base + 13);

        // Zero seed substitutes the reset seed
        base      = cyc;
        seed      = 8'h00;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        req       = 2'b01;
        expect_grant(2'b01, 8'h26, base + 10);
        wait_until(base + 10);
        req = 2'b00;
        wait_until(base + 13);

        // Both requesters held from reset: alternating grants 10 cycles apart
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base  = cyc;
        req   = 2'b11;
        b1 = 8'h26;
        b2 = model_next_byte(b1);
        b3 = model_next_byte(b2);
        b4 = model_next_byte(b3);
        expect_grant(2'b01, b1, base + 9);
        expect_grant(2'b10, b2, base + 19);
        expect_grant(2'b01, b3, base + 29);
        expect_grant(2'b10, b4, base + 39);
        wait_until(base + 39);
        req = 2'b00;
        wait_until(base + 42);

        // Reset on the 4th SHIFT cycle cancels the pending grant
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base  = cyc;
        req   = 2'b01;
        wait_until(base + 4);
        reset = 1'b1;
        req   = 2'b00;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_gnt",  32'(gnt),  32'h0);
        check("abort_data", 32'(data), 32'h0);
        repeat (12) tick();
        base = cyc;
        req  = 2'b01;
        expect_grant(2'b01, 8'h26, base + 9);
        wait_until(base + 9);
        req = 2'b00;
        wait_until(base + 12);

        // seed_load during SHIFT is ignored
        base = cyc;
        req  = 2'b01;
        expect_grant(2'b01, model_next_byte(8'h26), base + 9);
        wait_until(base + 3);
        seed      = 8'hFF;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        wait_until(base + 9);
        req = 2'b00;
        wait_until(base + 12);

        // Simultaneous seed_load and req: seed first, grant one cycle later
        tick();
        base      = cyc;
        seed      = 8'hFF;
        seed_load = 1'b1;
        req       = 2'b10;
        expect_grant(2'b10, 8'hD0, base + 10);
        tick();
        seed_load = 1'b0;
        wait_until(base + 10);
        req = 2'b00;
        wait_until(base + 13);

        repeat (3) tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
